// File: rtl/program_loader_if.sv
// Byte-stream input and CPU instruction-write/control bundle for the program loader.
// The loader uses slave; the byte source and the CPU side use master.
interface program_loader_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        i_load;
  logic [7:0]  o_instr_addr;
  logic [15:0] o_instr;
  logic        o_instr_we;
  logic        o_ON;
  logic        o_control_en;
  logic        o_cpu_rst;
  logic        o_busy;
  logic        o_err;

  modport master (
    output i_rx_data, i_rx_valid, i_load,
    input  o_instr_addr, o_instr, o_instr_we, o_ON, o_control_en, o_cpu_rst, o_busy, o_err
  );

  modport slave (
    input  i_rx_data, i_rx_valid, i_load,
    output o_instr_addr, o_instr, o_instr_we, o_ON, o_control_en, o_cpu_rst, o_busy, o_err
  );
endinterface

// File: rtl/program_loader.sv
// Frames, checksums and writes a boot image into CPU instruction memory, then releases the CPU.
// Word write strobe one cycle after its low byte; no backpressure, bytes are taken on every strobe.
module program_loader #(
  parameter int TIMEOUT  = 1000,
  parameter int TO_WIDTH = 20
) (
  input logic             i_clk,
  input logic             i_rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_CHK, S_RUN, S_ERR
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;

  state_t              state, state_nxt;
  logic [8:0]          remaining;
  logic [7:0]          addr;
  logic [7:0]          hi_byte;
  logic [7:0]          xor_acc;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                busy_st;
  logic                byte_vld;
  logic                timeout_hit;
  logic [7:0]          instr_addr_q;
  logic [15:0]         instr_q;
  logic                instr_we_q;
  logic                err_q;

  assign busy_st     = (state == S_COUNT) || (state == S_HI) || (state == S_LO) || (state == S_CHK);
  // A load request wins over a coincident byte, which is then dropped.
  assign byte_vld    = bus.i_rx_valid && !bus.i_load;
  assign timeout_hit = busy_st && !bus.i_rx_valid && (to_cnt == TO_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.i_load) begin
      state_nxt = S_IDLE;
    end else if (timeout_hit) begin
      state_nxt = S_ERR;
    end else if (bus.i_rx_valid) begin
      case (state)
        S_IDLE:  if (bus.i_rx_data == SYNC) state_nxt = S_COUNT;
        S_COUNT: state_nxt = S_HI;
        S_HI:    state_nxt = S_LO;
        S_LO:    state_nxt = (remaining == 9'd1) ? S_CHK : S_HI;
        S_CHK:   state_nxt = (bus.i_rx_data == xor_acc) ? S_RUN : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.o_ON         = (state == S_RUN);
    bus.o_control_en = (state == S_RUN);
    bus.o_cpu_rst    = (state != S_RUN);
    bus.o_busy       = busy_st;
    bus.o_err        = err_q;
    bus.o_instr_addr = instr_addr_q;
    bus.o_instr      = instr_q;
    bus.o_instr_we   = instr_we_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      remaining    <= '0;
      addr         <= '0;
      hi_byte      <= '0;
      xor_acc      <= '0;
      to_cnt       <= '0;
      instr_addr_q <= '0;
      instr_q      <= '0;
      instr_we_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      instr_we_q <= 1'b0;

      if (!busy_st || bus.i_rx_valid || bus.i_load) to_cnt <= '0;
      else                                          to_cnt <= to_cnt + 1'b1;

      if (state_nxt == S_ERR)        err_q <= 1'b1;
      else if (state_nxt == S_COUNT) err_q <= 1'b0;

      if (byte_vld) begin
        case (state)
          S_COUNT: begin
            // A count of zero stands for a full 256-word image.
            remaining <= (bus.i_rx_data == 8'h00) ? 9'd256 : {1'b0, bus.i_rx_data};
            addr      <= '0;
            xor_acc   <= bus.i_rx_data;
          end
          S_HI: begin
            hi_byte <= bus.i_rx_data;
            xor_acc <= xor_acc ^ bus.i_rx_data;
          end
          S_LO: begin
            instr_q      <= {hi_byte, bus.i_rx_data};
            instr_addr_q <= addr;
            instr_we_q   <= 1'b1;
            xor_acc      <= xor_acc ^ bus.i_rx_data;
            addr         <= addr + 8'd1;
            remaining    <= remaining - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, checksum, timeout, reload and async reset.
module tb_program_loader;
  localparam int TO = 40;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t wq[$];

  program_loader_if bus();

  program_loader #(.TIMEOUT(TO), .TO_WIDTH(20)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_instr_we) wq.push_back('{a: bus.o_instr_addr, d: bus.o_instr});
  end

  // Called at a negedge; returns at the next negedge with the byte accepted.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic pulse_load();
    bus.i_load = 1'b1;
    @(negedge clk);
    bus.i_load = 1'b0;
  endtask

  task automatic check_state(input string nm, input logic on, input logic crst,
                             input logic busy, input logic err);
    total++;
    if ({bus.o_ON, bus.o_control_en, bus.o_cpu_rst, bus.o_busy, bus.o_err} !== {on, on, crst, busy, err}) begin
      bad++;
      $display("FAIL %s: on/ce/cpu_rst/busy/err got %b%b%b%b%b want %b%b%b%b%b", nm,
               bus.o_ON, bus.o_control_en, bus.o_cpu_rst, bus.o_busy, bus.o_err, on, on, crst, busy, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.o_instr_addr, bus.o_instr, bus.o_instr_we} !== 25'h0) begin
      bad++;
      $display("FAIL reset_wr: addr/instr/we got %h/%h/%b want 00/0000/0",
               bus.o_instr_addr, bus.o_instr, bus.o_instr_we);
    end
    check_state("reset_ctl", 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    wq.delete();
    send_byte(8'hA5);
    check_state("nom_busy", 1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h42);
    check_state("nom_run", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 2) begin
      bad++;
      $display("FAIL nom_nwr: got %0d writes want 2", wq.size());
    end else begin
      total++;
      if (wq[0].a !== 8'h00 || wq[0].d !== 16'h1234) begin
        bad++;
        $display("FAIL nom_wr0: got %h@%h want 1234@00", wq[0].d, wq[0].a);
      end
      total++;
      if (wq[1].a !== 8'h01 || wq[1].d !== 16'hABCD) begin
        bad++;
        $display("FAIL nom_wr1: got %h@%h want abcd@01", wq[1].d, wq[1].a);
      end
    end
  endtask

  task automatic test_load_in_run();
    // Load and a sync byte together in RUN: IDLE next, byte dropped.
    bus.i_rx_data  = 8'hA5;
    bus.i_rx_valid = 1'b1;
    bus.i_load     = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    bus.i_load     = 1'b0;
    check_state("run_load", 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h02);
    check_state("run_load_idle", 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    wq.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h43);
    check_state("bad_err", 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 2) begin
      bad++;
      $display("FAIL bad_nwr: got %0d writes want 2", wq.size());
    end
    send_byte(8'hA5);
    check_state("bad_stuck", 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_load();
    check_state("bad_load_idle", 1'b0, 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    check_state("bad_err_clr", 1'b0, 1'b1, 1'b1, 1'b0);
    // Load mid-frame with a coincident byte aborts without a write.
    send_byte(8'h01);
    send_byte(8'h77);
    bus.i_rx_data  = 8'h88;
    bus.i_rx_valid = 1'b1;
    bus.i_load     = 1'b1;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    bus.i_load     = 1'b0;
    repeat (2) @(negedge clk);
    check_state("mid_load", 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (wq.size() != 2) begin
      bad++;
      $display("FAIL mid_load_nwr: got %0d writes want 2", wq.size());
    end
  endtask

  task automatic test_garbage();
    wq.delete();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check_state("garb_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h50);
    check_state("garb_run", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 1 || wq[0].a !== 8'h00 || wq[0].d !== 16'hBEEF) begin
      bad++;
      $display("FAIL garb_wr: got n=%0d first=%h want n=1 beef@00", wq.size(),
               (wq.size() > 0) ? wq[0].d : 16'hxxxx);
    end
    pulse_load();
  endtask

  task automatic test_full_frame();
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(8'(i));
    end
    send_byte(8'h00);
    check_state("full_run", 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() != 256) begin
      bad++;
      $display("FAIL full_nwr: got %0d writes want 256", wq.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        total++;
        if (wq[i].a !== 8'(i) || wq[i].d !== 16'(i * 16'h0101)) begin
          bad++;
          $display("FAIL full_wr%0d: got %h@%h want %h@%h", i, wq[i].d, wq[i].a,
                   16'(i * 16'h0101), 8'(i));
        end
      end
    end
    total++;
    if (bus.o_instr_addr !== 8'hFF) begin
      bad++;
      $display("FAIL full_addr_hold: got %h want ff", bus.o_instr_addr);
    end
    pulse_load();
  endtask

  task automatic test_timeout();
    wq.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
    repeat (TO - 1) @(negedge clk);
    check_state("to_before", 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_state("to_after", 1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (wq.size() != 0) begin
      bad++;
      $display("FAIL to_nwr: got %0d writes want 0", wq.size());
    end
    pulse_load();
  endtask

  task automatic test_reset_mid_frame();
    wq.delete();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({bus.o_instr_addr, bus.o_instr, bus.o_instr_we} !== 25'h0) begin
      bad++;
      $display("FAIL rstmid_wr: addr/instr/we got %h/%h/%b want 00/0000/0",
               bus.o_instr_addr, bus.o_instr, bus.o_instr_we);
    end
    check_state("rstmid_ctl", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'hCD); send_byte(8'h42);
    repeat (2) @(negedge clk);
    check_state("rstmid_idle", 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (wq.size() != 1) begin
      bad++;
      $display("FAIL rstmid_nwr: got %0d writes want 1", wq.size());
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_load     = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_load_in_run();
    test_bad_checksum();
    test_garbage();
    test_full_frame();
    test_timeout();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
